// File: rtl/serial_adder_unit.sv
// Bit-serial WIDTH-bit adder: one full_adder cell plus a carry flop, LSB first.
// Loads operands on start, shifts one bit pair per clock, pulses done with the result.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c0,
  output logic s,
  output logic c
);
  assign s = a ^ b ^ c0;
  assign c = (a & b) | (c0 & (a ^ b));
endmodule

module serial_adder_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] r_sh;
  logic [WIDTH-1:0] r_next;
  logic             cy;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_c;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .c0 (cy),
    .s  (fa_s),
    .c  (fa_c)
  );

  // r_sh keeps only the upper WIDTH-1 bits; the oldest bit falls off each shift
  assign r_next = {fa_s, r_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand/result datapath and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
      if (state == IDLE && start) begin
        a_sh <= a_in;
        b_sh <= b_in;
        cy   <= c_in;
        cnt  <= '0;
      end else if (state == SHIFT) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        r_sh <= r_next[WIDTH-1:1];
        cy   <= fa_c;
        cnt  <= CNT_W'(cnt + 1'b1);
        if (cnt == LAST) begin
          sum   <= r_next;
          c_out <= fa_c;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_unit.sv
// Self-checking bench for serial_adder_unit (WIDTH=8) against an arithmetic model.

module tb_serial_adder_unit;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         c_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W:0] hist [0:2599];

  serial_adder_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic ci);
    return {1'b0, a} + {1'b0, b} + (W+1)'(ci);
  endfunction

  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input string tag);
    int lat;
    int nbusy;
    logic [W:0] exp;
    lat = 0;
    nbusy = 0;
    exp = model(a, b, ci);
    @(negedge clk);
    a_in = a; b_in = b; c_in = ci; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (busy) nbusy++;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), W + 1);
    check({tag, "_busy_cycles"}, 32'(nbusy), W + 1);
    check({tag, "_result"}, 32'({c_out, sum}), 32'(exp));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int ndone;
    int last;
    int dcount;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;

    #12;
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_result", 32'({c_out, sum}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    do_add(8'h5A, 8'h3C, 1'b0, "t1");
    do_add(8'hFF, 8'h01, 1'b0, "t2");
    do_add(8'hFF, 8'hFF, 1'b1, "t3a");
    do_add(8'h00, 8'h00, 1'b0, "t3b");

    // Start pulses during SHIFT and in the DONE cycle must be ignored
    dcount = 0;
    @(negedge clk);
    a_in = 8'h01; b_in = 8'h01; c_in = 1'b0; start = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (done) begin
        dcount++;
        check("t4_done_cycle", 32'(k), W + 1);
        check("t4_result", 32'({c_out, sum}), 32'(model(8'h01, 8'h01, 1'b0)));
      end
      if (k == 3 || k == 9) begin
        start = 1'b1; a_in = 8'hF0;
      end else begin
        start = 1'b0;
      end
    end
    check("t4_done_count", 32'(dcount), 1);
    check("t4_hold_result", 32'({c_out, sum}), 32'h002);
    check("t4_idle", 32'(busy), 0);

    // Asynchronous reset in the middle of a shift sequence
    @(negedge clk);
    a_in = 8'h5A; b_in = 8'h3C; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_busy_before", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_done", 32'(done), 0);
    check("t5_rst_result", 32'({c_out, sum}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_add(8'h5A, 8'h3C, 1'b0, "t5_after");

    // start held high with random operands: result and done spacing
    ndone = 0;
    last = -1;
    for (int cyc = 0; cyc < 2600 && ndone < 200; cyc++) begin
      @(negedge clk);
      if (done) begin
        if (cyc >= W + 1)
          check("t6_result", 32'({c_out, sum}), 32'(hist[cyc-(W+1)]));
        else
          check("t6_early_done", 32'(cyc), W + 1);
        if (last >= 0) check("t6_spacing", 32'(cyc - last), W + 2);
        last = cyc;
        ndone++;
      end
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      a_in = ra; b_in = rb; c_in = rc; start = 1'b1;
      hist[cyc] = model(ra, rb, rc);
    end
    check("t6_done_count", 32'(ndone), 200);
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    check("t6_final_idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
